instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Encodes decoded instruction fields (mnemonic, register IDs, immediate/target) into 32-bit MIPS instruction words. It streams the words into instruction memory at consecutive word addresses. It is the inverse of the decode stage and serves as the program loader / self-check source for the single-cycle CPU: the same opcode/funct map, in the opposite direction. It has a valid/ready input handshake, a small FIFO, an address counter, and a load-session state machine.

Parameters:
DWIDTH, 32, instruction and immediate width
AWIDTH, 32, byte-address width of the instruction-memory write port
DEPTH, 4, encode FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load session at base_addr
base_addr  in  AWIDTH  first byte address (bits[1:0] ignored, forced 0)
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_mnem  in  4  mnemonic code (package enum)
in_rs  in  5  rs register ID
in_rt  in  5  rt register ID (destination for I-type)
in_rd  in  5  rd register ID (R-type destination)
in_imm  in  DWIDTH  signed immediate, or jump target for J/JAL
in_last  in  1  marks the final bundle of the session
imem_we  out  1  write request to instruction memory
imem_ready  in  1  memory accepts the write this cycle
imem_addr  out  AWIDTH  byte address of the write
imem_wdata  out  DWIDTH  encoded instruction
busy  out  1  session active (state not IDLE)
done  out  1  one-cycle pulse when the session completes
count  out  16  words written in the current or last session
err  out  1  sticky: an illegal bundle was seen this session
err_addr  out  AWIDTH  address of the first illegal bundle

Behaviour:
- Reset values (async, rst_n low): state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, count 0, err 0, err_addr 0, FIFO empty.
- States and transitions:
  - IDLE: start moves to LOAD. On entry to LOAD, the write pointer loads {base_addr[AWIDTH-1:2],2'b00}, count clears, and err/err_addr clear.
  - LOAD: in_ready = !fifo_full. A bundle is accepted when in_valid && in_ready; it is encoded combinationally and pushed into the FIFO at that edge. Accepting a bundle with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Write port: imem_we = !fifo_empty, imem_wdata = FIFO head, imem_addr = the write pointer. The write is performed when imem_we && imem_ready. On that edge: pop the FIFO, add 4 to the write pointer (mod 2^AWIDTH, wrapping silently), and increment count (saturates at 16'hFFFF).
- imem_we, imem_addr and imem_wdata hold stable while imem_ready is low.
- Latency: a bundle accepted on edge N reaches imem_we=1 in the cycle after N, provided no earlier entries are queued.
- FIFO: push and pop may occur on the same edge. in_ready depends only on registered full; there is no same-cycle bypass when full.
- Encoding: R-type uses opcode 000000, fields rs/rt/rd, shamt 0, with these funct values:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, NOR 100111, SLT 101010.
  - JR 001000, with rt=rd=0.
- Encoding: I-type uses {opcode, rs, rt, imm[15:0]} with these opcodes: ADDI 001000, SLTI 001010, LW 100011, SW 101011, BEQ 000100.
- Encoding: J-type uses {opcode, imm[25:0]} with J 000010 and JAL 000011.
- Encoding: NOP is 32'h0.
- Illegal bundles:
  - an undefined mnemonic;
  - I-type imm outside [-32768, 32767];
  - J/JAL with imm[DWIDTH-1:26] != 0.
- An illegal bundle is still accepted and writes 32'h00000000 (a NOP) at its address. err sets; err_addr captures that bundle's write address only if err was 0.
- Simultaneous events: start together with in_valid in IDLE means start wins and the bundle is not accepted (in_ready is 0 in IDLE). in_last with in_valid in the same cycle as FIFO full means not accepted and the bundle is held by the source.
- Reset mid-session aborts immediately to the reset values; queued words are discarded and never written.

Decomposition:
- Package encoder_pkg holds:
  - the mnemonic enum (4-bit);
  - opcode and funct localparams, the same values the decode stage uses;
  - the state enum;
  - the NOP constant.
- One sub-module is natural: sync_fifo (DWIDTH x DEPTH, push/pop/full/empty). Encoding stays as a combinational function inside instr_encoder.

Test Plan:
- ADD rs=1 rt=2 rd=3, base_addr=0x100, in_last=1, imem_ready=1 -> imem_wdata 0x00221820 at 0x100, count=1, done one cycle later.
- ADDI rs=0 rt=8 imm=-1; LW rs=29 rt=4 imm=8; J imm=0x100; JR rs=31 -> 0x2008FFFF @0, 0x8FA40008 @4, 0x08000100 @8, 0x03E00008 @C.
- BEQ rs=1 rt=2 imm=-2 with imem_ready held low 10 cycles, 6 bundles offered -> in_ready drops after 4 accepted; first word 0x1022FFFE held stable; all 6 written in order once ready rises.
- ADDI imm=40000 as the 2nd bundle, base 0x0 -> word 0x00000000 @4, err=1, err_addr=0x4; a later illegal bundle leaves err_addr=0x4.
- base_addr=0xFFFFFFFC, two bundles -> writes at 0xFFFFFFFC then 0x00000000.
- rst_n low mid-DRAIN with 3 queued -> imem_we=0 immediately, busy=0, count=0, no further writes.

Source files
------------

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - mnemonic/state enums and MIPS opcode/funct map shared with the decode stage
package encoder_pkg;

    typedef enum logic [3:0] {
        MN_NOP  = 4'd0,
        MN_ADD  = 4'd1,
        MN_SUB  = 4'd2,
        MN_AND  = 4'd3,
        MN_OR   = 4'd4,
        MN_NOR  = 4'd5,
        MN_SLT  = 4'd6,
        MN_JR   = 4'd7,
        MN_ADDI = 4'd8,
        MN_SLTI = 4'd9,
        MN_LW   = 4'd10,
        MN_SW   = 4'd11,
        MN_BEQ  = 4'd12,
        MN_J    = 4'd13,
        MN_JAL  = 4'd14
    } mnem_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy and same-edge push/pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction field bundles into MIPS words and streams them to imem
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [DWIDTH-1:0] in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [DWIDTH-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       count,
    output logic              err,
    output logic [AWIDTH-1:0] err_addr
);

    // Returns {illegal, word}; illegal bundles collapse to a NOP word.
    function automatic logic [DWIDTH:0] encode(
        input logic [3:0]        mnem,
        input logic [4:0]        rs,
        input logic [4:0]        rt,
        input logic [4:0]        rd,
        input logic [DWIDTH-1:0] imm
    );
        logic [31:0] w;
        logic        bad;
        logic        i_ok;
        logic        j_ok;
        i_ok = (imm[DWIDTH-1:15] == '0) || (&imm[DWIDTH-1:15]);
        j_ok = (imm[DWIDTH-1:26] == '0);
        bad  = 1'b0;
        w    = NOP_WORD;
        case (mnem)
            MN_NOP:  w = NOP_WORD;
            MN_ADD:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_AND:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            MN_OR:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            MN_NOR:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
            MN_SLT:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            MN_JR:   w = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            MN_ADDI: begin w = {OP_ADDI, rs, rt, imm[15:0]}; bad = !i_ok; end
            MN_SLTI: begin w = {OP_SLTI, rs, rt, imm[15:0]}; bad = !i_ok; end
            MN_LW:   begin w = {OP_LW,   rs, rt, imm[15:0]}; bad = !i_ok; end
            MN_SW:   begin w = {OP_SW,   rs, rt, imm[15:0]}; bad = !i_ok; end
            MN_BEQ:  begin w = {OP_BEQ,  rs, rt, imm[15:0]}; bad = !i_ok; end
            MN_J:    begin w = {OP_J,   imm[25:0]}; bad = !j_ok; end
            MN_JAL:  begin w = {OP_JAL, imm[25:0]}; bad = !j_ok; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            w = NOP_WORD;
        end
        return {bad, DWIDTH'(w)};
    endfunction

    state_e            state;
    state_e            state_nxt;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] acc_addr;
    logic [AWIDTH-1:0] base_aligned;
    logic [DWIDTH:0]   enc;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              wr_fire;
    logic              start_session;

    assign base_aligned  = base_addr & ~AWIDTH'(3);
    assign enc           = encode(in_mnem, in_rs, in_rt, in_rd, in_imm);
    assign accept        = in_valid && in_ready;
    assign wr_fire       = imem_we && imem_ready;
    assign start_session = (state == ST_IDLE) && start;
    assign imem_we       = !fifo_empty;
    assign imem_addr     = wr_ptr;

    sync_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (enc[DWIDTH-1:0]),
        .pop       (wr_fire),
        .pop_data  (imem_wdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (accept && in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            ST_IDLE:  busy = 1'b0;
            ST_LOAD:  in_ready = !fifo_full;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // acc_addr tracks where the next accepted bundle will land, so err_addr is known at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            acc_addr <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else if (start_session) begin
            wr_ptr   <= base_aligned;
            acc_addr <= base_aligned;
            count    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AWIDTH'(4);
                if (count != 16'hFFFF) begin
                    count <= count + 16'd1;
                end
            end
            if (accept) begin
                acc_addr <= acc_addr + AWIDTH'(4);
                if (enc[DWIDTH] && !err) begin
                    err      <= 1'b1;
                    err_addr <= acc_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        in_last;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    localparam logic [3:0] M_NOP = 4'd0, M_ADD = 4'd1, M_SUB = 4'd2, M_JR = 4'd7,
                           M_ADDI = 4'd8, M_LW = 4'd10, M_BEQ = 4'd12, M_J = 4'd13,
                           M_BAD = 4'd15;

    instr_encoder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mnem    (in_mnem),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .err        (err),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change on the falling edge; sample just after, which is what the next rising edge sees.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && imem_we && imem_ready) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_session(input logic [31:0] base);
        got_a.delete();
        got_d.delete();
        exp_a.delete();
        exp_d.delete();
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_mnem  = m;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_last  = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        in_valid   = 1'b0;
        in_mnem    = '0;
        in_rs      = '0;
        in_rt      = '0;
        in_rd      = '0;
        in_imm     = '0;
        in_last    = 1'b0;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_in_ready",   32'(in_ready), 32'd0);
        check("rst_imem_we",    32'(imem_we),  32'd0);
        check("rst_imem_addr",  imem_addr,     32'd0);
        check("rst_imem_wdata", imem_wdata,    32'd0);
        check("rst_busy",       32'(busy),     32'd0);
        check("rst_done",       32'(done),     32'd0);
        check("rst_count",      32'(count),    32'd0);
        check("rst_err",        32'(err),      32'd0);
        check("rst_err_addr",   err_addr,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD, one-cycle latency to the write port
        start_session(32'h100);
        check("t1_busy", 32'(busy), 32'd1);
        send(M_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        check("t1_lat_we",   32'(imem_we), 32'd1);
        check("t1_lat_addr", imem_addr,    32'h100);
        check("t1_lat_data", imem_wdata,   32'h0022_1820);
        expect_wr(32'h100, 32'h0022_1820);
        wait_done("t1");
        check_writes("t1");
        check("t1_count", 32'(count), 32'd1);

        // Mixed I/J/R formats at consecutive addresses
        start_session(32'h0);
        send(M_ADDI, 5'd0,  5'd8, 5'd0, 32'hFFFF_FFFF, 1'b0);
        send(M_LW,   5'd29, 5'd4, 5'd0, 32'd8,         1'b0);
        send(M_J,    5'd0,  5'd0, 5'd0, 32'h100,       1'b0);
        send(M_JR,   5'd31, 5'd0, 5'd0, 32'd0,         1'b1);
        expect_wr(32'h0, 32'h2008_FFFF);
        expect_wr(32'h4, 32'h8FA4_0008);
        expect_wr(32'h8, 32'h0800_0100);
        expect_wr(32'hC, 32'h03E0_0008);
        wait_done("t2");
        check_writes("t2");
        check("t2_count", 32'(count), 32'd4);
        check("t2_err",   32'(err),   32'd0);

        // Backpressure: FIFO fills at 4, head holds stable
        imem_ready = 1'b0;
        start_session(32'h200);
        for (int i = 0; i < 4; i++) begin
            send(M_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFE - 32'(i), 1'b0);
        end
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_head_we",    32'(imem_we),  32'd1);
        check("t3_head_data",  imem_wdata,    32'h1022_FFFE);
        check("t3_head_addr",  imem_addr,     32'h200);
        repeat (3) @(negedge clk);
        check("t3_hold_data", imem_wdata,    32'h1022_FFFE);
        check("t3_hold_addr", imem_addr,     32'h200);
        check("t3_hold_cnt",  32'(count),    32'd0);
        fork
            begin
                repeat (3) @(negedge clk);
                imem_ready = 1'b1;
            end
            begin
                send(M_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFA, 1'b0);
                send(M_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF9, 1'b1);
            end
        join
        for (int i = 0; i < 6; i++) begin
            expect_wr(32'h200 + 32'(4 * i), 32'h1022_FFFE - 32'(i));
        end
        wait_done("t3");
        check_writes("t3");
        check("t3_count", 32'(count), 32'd6);

        // Illegal bundles: out-of-range imm, J high bits, undefined mnemonic
        start_session(32'h0);
        send(M_ADDI, 5'd0, 5'd8, 5'd0, 32'hFFFF_8000, 1'b0);
        send(M_ADDI, 5'd0, 5'd8, 5'd0, 32'd40000,     1'b0);
        send(M_J,    5'd0, 5'd0, 5'd0, 32'h0400_0000, 1'b0);
        send(M_BAD,  5'd1, 5'd2, 5'd3, 32'd0,         1'b1);
        expect_wr(32'h0, 32'h2008_8000);
        expect_wr(32'h4, 32'h0);
        expect_wr(32'h8, 32'h0);
        expect_wr(32'hC, 32'h0);
        wait_done("t4");
        check_writes("t4");
        check("t4_err",      32'(err), 32'd1);
        check("t4_err_addr", err_addr, 32'h4);

        // Address wrap, low base bits ignored, err cleared by new session
        start_session(32'hFFFF_FFFE);
        check("t5_err_clr", 32'(err), 32'd0);
        send(M_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        send(M_SUB, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        expect_wr(32'hFFFF_FFFC, 32'h0);
        expect_wr(32'h0,         32'h0022_1822);
        wait_done("t5");
        check_writes("t5");
        check("t5_count", 32'(count), 32'd2);

        // Reset mid-drain discards queued words
        imem_ready = 1'b0;
        start_session(32'h40);
        send(M_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        send(M_ADD, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
        send(M_ADD, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
        check("t6_pre_busy", 32'(busy),    32'd1);
        check("t6_pre_we",   32'(imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we",    32'(imem_we), 32'd0);
        check("t6_rst_busy",  32'(busy),    32'd0);
        check("t6_rst_count", 32'(count),   32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_writes", 32'(got_a.size()), 32'd0);
        check("t6_idle_we",   32'(imem_we),      32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
